// File: rtl/seq_addsub_unit_if.sv
// Handshake and result bundle for the sequential adder/subtractor.
interface seq_addsub_unit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             v;
    logic             z;
    logic             n;

    modport master (
        output start, mode, a, b,
        input  busy, done, result, cout, v, z, n
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, result, cout, v, z, n
    );
endinterface

// File: rtl/seq_addsub_unit.sv
// Multi-cycle add/sub, CHUNK bits per clock with a registered ripple carry.
// Define SEQ_ADDSUB_SATURATE_EN to clamp overflowing results to the signed limit.
module seq_addsub_unit #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_addsub_unit_if.slave   bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             v_q, v_d;
    logic             z_q, z_d;
    logic             n_q, n_d;

    logic [CHUNK-1:0] ca, cb, cs;
    logic [CHUNK:0]   csum;
    logic             msb_cin;
    logic             last;
    logic             ovf;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] fin;

    always_comb begin
        ca      = opa_q[int'(cnt_q)*CHUNK +: CHUNK];
        cb      = opb_q[int'(cnt_q)*CHUNK +: CHUNK];
        csum    = {1'b0, ca} + {1'b0, cb}
                + {{CHUNK{1'b0}}, carry_q};
        cs      = csum[CHUNK-1:0];
        // carry into the chunk's top bit recovered from its sum bit
        msb_cin = cs[CHUNK-1] ^ ca[CHUNK-1] ^ cb[CHUNK-1];
        last    = (cnt_q == CW'(NCH - 1));
        ovf     = msb_cin ^ csum[CHUNK];
        raw     = sum_q;
        raw[int'(cnt_q)*CHUNK +: CHUNK] = cs;
`ifdef SEQ_ADDSUB_SATURATE_EN
        if (ovf) begin
            fin = opa_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            fin = raw;
        end
`else
        fin = raw;
`endif
    end

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        cout_d   = cout_q;
        v_d      = v_q;
        z_d      = z_q;
        n_d      = n_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    opa_d   = bus.a;
                    opb_d   = bus.b ^ {WIDTH{bus.mode}};
                    sum_d   = '0;
                    carry_d = bus.mode;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d   = raw;
                carry_d = csum[CHUNK];
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = fin;
                    cout_d   = csum[CHUNK];
                    v_d      = ovf;
                    z_d      = (fin == '0);
                    n_d      = fin[WIDTH-1];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            v_q      <= v_d;
            z_q      <= z_d;
            n_q      <= n_d;
        end
    end

    assign bus.busy   = (state_q == S_RUN);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.v      = v_q;
    assign bus.z      = z_q;
    assign bus.n      = n_q;
endmodule

// File: tb/tb_seq_addsub_unit.sv
// Directed-vector bench for seq_addsub_unit (WIDTH=8, CHUNK=2).
module tb_seq_addsub_unit;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    logic [7:0] prev_res;

    seq_addsub_unit_if #(.WIDTH(8)) bus ();

    seq_addsub_unit #(.WIDTH(8), .CHUNK(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic m,
                         input logic [7:0] a, input logic [7:0] b);
        bus.start = s;
        bus.mode  = m;
        bus.a     = a;
        bus.b     = b;
    endtask

    // Issue one op and check timing, held outputs and final flags.
    task automatic run_op(input string tag, input logic m,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] er, input logic ec,
                          input logic ev, input logic ez,
                          input logic en);
        drive(1'b1, m, a, b);
        step();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_nodone"}, 32'(bus.done), 32'd0);
            if (i == 1) chk({tag, "_hold"}, 32'(bus.result), 32'(prev_res));
            step();
        end
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_idlebusy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_res"}, 32'(bus.result), 32'(er));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        chk({tag, "_v"}, 32'(bus.v), 32'(ev));
        chk({tag, "_z"}, 32'(bus.z), 32'(ez));
        chk({tag, "_n"}, 32'(bus.n), 32'(en));
        prev_res = er;
        step();
        chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_keep"}, 32'(bus.result), 32'(er));
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        prev_res = 8'h00;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        #12;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_res", 32'(bus.result), 32'd0);
        chk("rst_flags", {28'd0, bus.cout, bus.v, bus.z, bus.n}, 32'd0);
        rst_n = 1'b1;
        step();

        run_op("add3c05", 1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sub0505", 1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef SEQ_ADDSUB_SATURATE_EN
        run_op("add7f01", 1'b0, 8'h7F, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("sub8001", 1'b1, 8'h80, 8'h01, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1);
`else
        run_op("add7f01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("sub8001", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
        run_op("addff01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

        // mid-RUN start pulse and operand changes must be ignored
        drive(1'b1, 1'b0, 8'h10, 8'h20);
        step();
        drive(1'b0, 1'b0, 8'h10, 8'h20);
        step();
        drive(1'b1, 1'b1, 8'hFF, 8'hFF);
        step();
        drive(1'b0, 1'b1, 8'hFF, 8'hFF);
        step();
        chk("mid_nodone", 32'(bus.done), 32'd0);
        step();
        chk("mid_done", 32'(bus.done), 32'd1);
        chk("mid_res", 32'(bus.result), 32'h30);
        // back-to-back start while in DONE
        drive(1'b1, 1'b0, 8'h01, 8'h01);
        step();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        chk("b2b_single", 32'(bus.done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("b2b_nodone", 32'(bus.done), 32'd0);
        end
        step();
        chk("b2b_done", 32'(bus.done), 32'd1);
        chk("b2b_res", 32'(bus.result), 32'h02);
        prev_res = 8'h02;
        step();

        // async reset during the 2nd RUN cycle
        drive(1'b1, 1'b0, 8'h3C, 8'h05);
        step();
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_res", 32'(bus.result), 32'd0);
        chk("arst_flags", {28'd0, bus.cout, bus.v, bus.z, bus.n}, 32'd0);
        step();
        step();
        chk("arst_hold", 32'(bus.result), 32'd0);
        rst_n = 1'b1;
        prev_res = 8'h00;
        step();
        run_op("sub0102", 1'b1, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
